// File: rtl/reg_file_dual_wr.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_dual_wr
//  Brief    : Parametrised register file with two registered read ports,
//             two write ports (port 1 has priority on a collision), a PC
//             read-through alias on index NREGS-1 and a combinational
//             debug read port.
//  Options  : REGFILE_BYPASS_EN - when defined, rd1/rd2 see same-edge write
//             data (write-first); otherwise reads are read-before-write.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_dual_wr #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int NREGS     = 16,
    parameter int PC_OFFSET = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] wa2,
    input  logic [DATA_W-1:0] wd2,
    input  logic [DATA_W-1:0] pc_in,
    output logic              wr_pc_err,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    // Only indices 0..NREGS-2 are real storage; NREGS-1 aliases the PC.
    localparam int                c_NSTORE    = NREGS - 1;
    localparam logic [ADDR_W:0]   c_PC_IDX    = (ADDR_W+1)'(NREGS - 1);
    localparam logic [DATA_W-1:0] c_PC_OFFSET = DATA_W'(PC_OFFSET);

    logic [DATA_W-1:0] r_mem [c_NSTORE];
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic              r_wr_pc_err;

    logic              w_wa1_bad;
    logic              w_wa2_bad;
    logic [DATA_W-1:0] w_pc_view;
    logic [DATA_W-1:0] w_rd1_nxt;
    logic [DATA_W-1:0] w_rd2_nxt;

    // A write address is illegal when it hits the PC alias or beyond.
    assign w_wa1_bad = ({1'b0, wa1} >= c_PC_IDX);
    assign w_wa2_bad = ({1'b0, wa2} >= c_PC_IDX);
    assign w_pc_view = pc_in + c_PC_OFFSET;

    // Architectural view of one address: storage, PC alias, or zero above it.
    function automatic logic [DATA_W-1:0] f_array_read(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if ({1'b0, a} == c_PC_IDX) begin
            v = w_pc_view;
        end else if ({1'b0, a} < c_PC_IDX) begin
            for (int i = 0; i < c_NSTORE; i++) begin
                if (a == ADDR_W'(i)) begin
                    v = r_mem[i];
                end
            end
        end
        return v;
    endfunction

    // Storage flops: port 1 is tested first so it wins an address collision;
    // illegal addresses never match any index, so they are dropped here.
    generate
        for (genvar gi = 0; gi < c_NSTORE; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] c_IDX = ADDR_W'(gi);
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mem[gi] <= '0;
                end else if (we1 && (wa1 == c_IDX)) begin
                    r_mem[gi] <= wd1;
                end else if (we2 && (wa2 == c_IDX)) begin
                    r_mem[gi] <= wd2;
                end
            end
        end
    endgenerate

    // Next read data; with bypass, legal same-edge writes override the array
    // (port 2 applied first so port 1 data wins on a shared address).
    always_comb begin
        w_rd1_nxt = f_array_read(ra1);
        w_rd2_nxt = f_array_read(ra2);
`ifdef REGFILE_BYPASS_EN
        if (we2 && !w_wa2_bad && (wa2 == ra1)) w_rd1_nxt = wd2;
        if (we1 && !w_wa1_bad && (wa1 == ra1)) w_rd1_nxt = wd1;
        if (we2 && !w_wa2_bad && (wa2 == ra2)) w_rd2_nxt = wd2;
        if (we1 && !w_wa1_bad && (wa1 == ra2)) w_rd2_nxt = wd1;
`else
        // Read-before-write: the array value sampled at the edge is returned.
`endif
    end

    // Registered read ports; re low stalls them at their current value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd1 <= '0;
            r_rd2 <= '0;
        end else if (re) begin
            r_rd1 <= w_rd1_nxt;
            r_rd2 <= w_rd2_nxt;
        end
    end

    // One pulse per edge on which either port targeted an illegal address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_pc_err <= 1'b0;
        end else begin
            r_wr_pc_err <= (we1 && w_wa1_bad) || (we2 && w_wa2_bad);
        end
    end

    assign rd1       = r_rd1;
    assign rd2       = r_rd2;
    assign wr_pc_err = r_wr_pc_err;
    assign dbg_data  = f_array_read(dbg_addr);

endmodule
`default_nettype wire
